// File: rtl/asteroids_pkg.sv
// Shared definitions for the bullet dispatcher: FSM state encoding, counter widths and
// the slot-index width helper.
package asteroids_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int SHOTS_W = 16;
  localparam int DROPS_W = 8;
  localparam int CD_W    = 8;
  localparam int TMO_W   = 3;

  // Index width for a pool of n slots; a single slot still needs one bit.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bullet_dispatcher_slot_picker.sv
// Combinational priority encoder: lowest index whose in_use bit is clear.
module slot_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  in_use,
  output logic [SW-1:0] slot,
  output logic          found
);

  always_comb begin
    slot  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!in_use[i] && !found) begin
        slot  = SW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_dispatcher.sv
// Fire button -> one-hot bullet start pulse with cooldown, inUse confirmation and stats.
// Optional AUTO_FIRE_EN: fire request follows the button level instead of its rising edge.
module bullet_dispatcher
  import asteroids_pkg::*;
#(
  parameter int NUM_BULLETS     = 4,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int ACK_TIMEOUT     = 3
) (
  input  logic                   clk_60hz,
  input  logic                   reset,
  input  logic                   fire_btn,
  input  logic                   dir_up,
  input  logic [NUM_BULLETS-1:0] inUse,
  output logic [NUM_BULLETS-1:0] start_bullet,
  output logic                   direction,
  output logic                   busy,
  output logic [SHOTS_W-1:0]     shots_fired,
  output logic [DROPS_W-1:0]     shots_dropped,
  output logic                   ack_error
);

  localparam int SW = slot_w(NUM_BULLETS);
  localparam logic [CD_W-1:0]  CD_INIT  = (COOLDOWN_FRAMES == 0) ? '0 : CD_W'(COOLDOWN_FRAMES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [SW-1:0]            slot_q, slot_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [CD_W-1:0]          cd_q, cd_d;
  logic                     fire_prev;
  logic [NUM_BULLETS-1:0]   start_d;
  logic                     dir_d;
  logic [SHOTS_W-1:0]       fired_d;
  logic [DROPS_W-1:0]       dropped_d;
  logic                     err_d;
  logic [SW-1:0]            pick_slot;
  logic                     pick_found;
  logic                     fire_req;
  logic                     exit_issue;

  slot_picker #(
    .N  (NUM_BULLETS),
    .SW (SW)
  ) u_picker (
    .in_use (inUse),
    .slot   (pick_slot),
    .found  (pick_found)
  );

`ifdef AUTO_FIRE_EN
  assign fire_req = fire_btn;
`else
  assign fire_req = fire_btn & ~fire_prev;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      tmo_q         <= '0;
      cd_q          <= '0;
      fire_prev     <= 1'b1;
      start_bullet  <= '0;
      direction     <= 1'b0;
      shots_fired   <= '0;
      shots_dropped <= '0;
      ack_error     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      tmo_q         <= tmo_d;
      cd_q          <= cd_d;
      fire_prev     <= fire_btn;
      start_bullet  <= start_d;
      direction     <= dir_d;
      shots_fired   <= fired_d;
      shots_dropped <= dropped_d;
      ack_error     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    tmo_d      = tmo_q;
    cd_d       = cd_q;
    start_d    = start_bullet;
    dir_d      = direction;
    fired_d    = shots_fired;
    dropped_d  = shots_dropped;
    err_d      = ack_error;
    exit_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_req) begin
          if (pick_found) begin
            start_d = NUM_BULLETS'(1) << pick_slot;
            dir_d   = dir_up;
            slot_d  = pick_slot;
            tmo_d   = '0;
            state_d = ISSUE;
          end else if (shots_dropped != '1) begin
            dropped_d = shots_dropped + 1'b1;
          end
        end
      end
      ISSUE: begin
        // Acknowledge wins over a timeout landing in the same frame.
        if (inUse[slot_q]) begin
          start_d    = '0;
          fired_d    = shots_fired + 1'b1;
          exit_issue = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          start_d    = '0;
          err_d      = 1'b1;
          exit_issue = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (exit_issue) begin
          state_d = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
          cd_d    = CD_INIT;
        end
      end
      COOLDOWN: begin
        if (cd_q == '0) state_d = IDLE;
        else            cd_d    = cd_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bullet_dispatcher.sv
// Directed self-checking bench for bullet_dispatcher (default parameters 4/10/3).
// Build with AUTO_FIRE_EN defined to exercise the level-triggered auto-fire path.
module tb_bullet_dispatcher;

  logic        clk_60hz;
  logic        reset;
  logic        fire_btn;
  logic        dir_up;
  logic [3:0]  inUse;
  logic [3:0]  start_bullet;
  logic        direction;
  logic        busy;
  logic [15:0] shots_fired;
  logic [7:0]  shots_dropped;
  logic        ack_error;

  int total = 0;
  int bad   = 0;

  bullet_dispatcher #(
    .NUM_BULLETS     (4),
    .COOLDOWN_FRAMES (10),
    .ACK_TIMEOUT     (3)
  ) dut (
    .clk_60hz      (clk_60hz),
    .reset         (reset),
    .fire_btn      (fire_btn),
    .dir_up        (dir_up),
    .inUse         (inUse),
    .start_bullet  (start_bullet),
    .direction     (direction),
    .busy          (busy),
    .shots_fired   (shots_fired),
    .shots_dropped (shots_dropped),
    .ack_error     (ack_error)
  );

  initial begin
    clk_60hz = 1'b0;
    forever #5 clk_60hz = ~clk_60hz;
  end

  task automatic tick();
    @(posedge clk_60hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press();
    fire_btn = 1'b1;
    tick();
    fire_btn = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    int rises;
    int first_rise;
    int second_rise;
    logic [3:0] prev_start;

    reset = 1'b1; fire_btn = 1'b0; dir_up = 1'b0; inUse = 4'b0000;
    tick(); tick();
    chk("rst_start", start_bullet, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dir", direction, 1'b0);
    chk("rst_fired", shots_fired, 16'd0);
    chk("rst_dropped", shots_dropped, 8'd0);
    chk("rst_err", ack_error, 1'b0);
    reset = 1'b0;
    tick();

    // 1: basic launch into slot 0, ack, 10 cooldown frames
    fire_btn = 1'b1; dir_up = 1'b1;
    tick();
    chk("t1_start", start_bullet, 4'b0001);
    chk("t1_dir", direction, 1'b1);
    chk("t1_busy_issue", busy, 1'b1);
    fire_btn = 1'b0; inUse = 4'b0001;
    tick();
    chk("t1_start_low", start_bullet, 4'b0000);
    chk("t1_fired", shots_fired, 16'd1);
    cnt = busy ? 1 : 0;
    inUse = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) cnt++;
      else break;
    end
    chk("t1_cooldown_frames", cnt, 10);

    // 2: lowest free slot is 2; direction latched at accept
    inUse = 4'b1011; dir_up = 1'b0; fire_btn = 1'b1;
    tick();
    chk("t2_start", start_bullet, 4'b0100);
    chk("t2_dir", direction, 1'b0);
    fire_btn = 1'b0; dir_up = 1'b1;
    tick();
    chk("t2_start_held", start_bullet, 4'b0100);
    chk("t2_dir_stable", direction, 1'b0);
    inUse = 4'b1111;
    tick();
    chk("t2_start_low", start_bullet, 4'b0000);
    chk("t2_fired", shots_fired, 16'd2);
    repeat (10) tick();
    chk("t2_idle", busy, 1'b0);

    // 3: no free slot -> drops, saturating at 255
    repeat (3) press();
    chk("t3_no_start", start_bullet, 4'b0000);
    chk("t3_dropped3", shots_dropped, 8'd3);
    chk("t3_busy", busy, 1'b0);
    repeat (255) press();
    chk("t3_dropped_sat", shots_dropped, 8'd255);

    // 4: never acked -> start held exactly 3 frames, then abort
    inUse = 4'b0000; fire_btn = 1'b1;
    tick();
    fire_btn = 1'b0;
    chk("t4_start", start_bullet, 4'b0001);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_bullet != 4'b0000) cnt++;
      else break;
    end
    chk("t4_held_frames", cnt, 3);
    chk("t4_ack_error", ack_error, 1'b1);
    chk("t4_fired_same", shots_fired, 16'd2);
    chk("t4_cooldown", busy, 1'b1);

    // 5: press during cooldown ignored
    press();
    chk("t5_no_start", start_bullet, 4'b0000);
    chk("t5_dropped_same", shots_dropped, 8'd255);
    chk("t5_fired_same", shots_fired, 16'd2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
      cnt++;
    end
    chk("t5_back_idle", busy, 1'b0);
    chk("t5_cd_remaining", cnt, 8);
    chk("t5_no_late_start", start_bullet, 4'b0000);
    chk("t5_err_sticky", ack_error, 1'b1);

`ifndef AUTO_FIRE_EN
    // Button held across reset release must not fire
    fire_btn = 1'b1;
`endif
    reset = 1'b1;
    tick();
    chk("t5_rst_err", ack_error, 1'b0);
    chk("t5_rst_dropped", shots_dropped, 8'd0);
    reset = 1'b0;
`ifndef AUTO_FIRE_EN
    repeat (3) tick();
    chk("t5_held_no_fire", start_bullet, 4'b0000);
    chk("t5_held_idle", busy, 1'b0);
    fire_btn = 1'b0;
`endif
    tick();
    fire_btn = 1'b1;
    tick();
    fire_btn = 1'b0;
    chk("t5_repress_start", start_bullet, 4'b0001);

    // Async reset while start is high
    #2 reset = 1'b1;
    #1;
    chk("t6_async_start", start_bullet, 4'b0000);
    chk("t6_async_fired", shots_fired, 16'd0);
    chk("t6_async_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Held button with every launch acknowledged
    fire_btn = 1'b1;
    rises = 0; first_rise = -1; second_rise = -1;
    prev_start = 4'b0000;
    for (int f = 1; f <= 40; f++) begin
      tick();
      if (start_bullet != 4'b0000 && prev_start == 4'b0000) begin
        rises++;
        if (first_rise < 0) first_rise = f;
        else if (second_rise < 0) second_rise = f;
      end
      prev_start = start_bullet;
      inUse = start_bullet;
    end
    fire_btn = 1'b0;
    chk("t6_first_rise", first_rise, 1);
`ifdef AUTO_FIRE_EN
    chk("t6_auto_rises", rises, 4);
    chk("t6_auto_period", second_rise - first_rise, 12);
`else
    chk("t6_single_launch", rises, 1);
`endif
    chk("t6_fired", shots_fired, 32'(rises));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
